// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_e;

  localparam int DIV_W = 32;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_if.sv
// start/busy/done handshake and operand/result bus between control unit and divider.
interface seq_divider_if #(
  parameter int N = div_pkg::DIV_W
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_div,
  output logic [N-1:0] o_rem,
  output logic         o_q
);

  logic [N:0] w_shift;
  logic [N:0] w_t;

  // Partial remainder is always below the divisor, so N+1 bits hold the trial difference exactly.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_t     = w_shift - {1'b0, i_div};
    o_q     = ~w_t[N];
    o_rem   = o_q ? w_t[N-1:0] : w_shift[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Signed operation is built in only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(N);

  div_state_e     r_state;
  div_state_e     w_state_nxt;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_div;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_remd;
  logic [CNT_W-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;

  logic           w_accept;
  logic           w_div0;
  logic           w_ovf;
  logic           w_special;
  logic [N-1:0]   w_dvd_mag;
  logic [N-1:0]   w_dvs_mag;
  logic [N-1:0]   w_spec_q;
  logic [N-1:0]   w_spec_r;
  logic [N-1:0]   w_step_rem;
  logic           w_step_q;
  logic [N-1:0]   w_quot_res;
  logic [N-1:0]   w_rem_res;

  // r_busy also covers the done cycle, which keeps a start in that cycle from being taken.
  assign w_accept = (r_state == IDLE) && !r_busy && bus.start;
  assign w_div0   = (bus.divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_qneg;
  logic r_rneg;

  always_comb begin
    w_dvd_neg = bus.is_signed & bus.dividend[N-1];
    w_dvs_neg = bus.is_signed & bus.divisor[N-1];
    w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;
    w_ovf     = bus.is_signed && (bus.dividend == {1'b1, {(N-1){1'b0}}}) && (bus.divisor == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (w_accept) begin
      r_qneg <= !w_special && (w_dvd_neg ^ w_dvs_neg);
      r_rneg <= !w_special && w_dvd_neg;
    end
  end

  always_comb begin
    w_quot_res = r_qneg ? -r_q   : r_q;
    w_rem_res  = r_rneg ? -r_rem : r_rem;
  end
`else
  always_comb begin
    w_dvd_mag  = bus.dividend;
    w_dvs_mag  = bus.divisor;
    w_ovf      = 1'b0;
    w_quot_res = r_q;
    w_rem_res  = r_rem;
  end
`endif

  always_comb begin
    w_special = w_div0 || w_ovf;
    w_spec_q  = w_div0 ? '1 : {1'b1, {(N-1){1'b0}}};
    w_spec_r  = w_div0 ? bus.dividend : '0;
  end

  div_step #(.N(N)) u_step (
    .i_rem (r_rem),
    .i_bit (r_q[N-1]),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? FIN : CALC;
      CALC:    if (r_cnt == '0) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Special cases preload their final answer into r_q/r_rem so FIN treats every path alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy <= !w_special;
            r_cnt  <= CNT_W'(N-1);
            r_div  <= w_dvs_mag;
            r_q    <= w_special ? w_spec_q : w_dvd_mag;
            r_rem  <= w_special ? w_spec_r : '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_q   <= {r_q[N-2:0], w_step_q};
          r_cnt <= r_cnt - 1'b1;
        end
        FIN: begin
          r_quot <= w_quot_res;
          r_remd <= w_rem_res;
          r_done <= 1'b1;
          r_busy <= 1'b1;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remd;

endmodule

// File: tb/tb_seq_divider.sv
// Directed + scoreboard bench for seq_divider; expectations follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;
  import div_pkg::*;

  localparam int N = DIV_W;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.N(N)) u_if ();
  seq_divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           k;
    int           lat;
    int           bsy;
  } exp_t;

  exp_t sb[$];
  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int n_done   = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (u_if.busy) busy_cnt++;
      if (u_if.done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("spurious_done", u_if.done, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("quotient",    u_if.quotient,  e.q);
          chk("remainder",   u_if.remainder, e.r);
          chk("latency",     cyc - e.k,      e.lat);
          chk("busy_cycles", busy_cnt,       e.bsy);
        end
        busy_cnt = 0;
      end
    end
  end

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                output logic [N-1:0] q, output logic [N-1:0] r, output logic sp);
    sp = 1'b0;
    if (b == '0) begin
      q = DIV_ZERO_Q; r = a; sp = 1'b1;
    end else if (SGN_EN && s) begin
      if (a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
        q = a; r = '0; sp = 1'b1;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called #1 after a clock edge with the DUT idle; scrambles operands once accepted.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic sp);
    exp_t e;
    u_if.start     = 1'b1;
    u_if.dividend  = a;
    u_if.divisor   = b;
    u_if.is_signed = s;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.k = cyc;
    e.lat = sp ? 1 : N + 1;
    e.bsy = sp ? 1 : N + 2;
    sb.push_back(e);
    u_if.start     = 1'b0;
    u_if.dividend  = $urandom;
    u_if.divisor   = $urandom;
    u_if.is_signed = ~s;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !u_if.busy) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b, eq, er;
    logic         sp;
    int           d0;

    rst_n = 1'b0;
    u_if.start = 1'b0; u_if.is_signed = 1'b0; u_if.dividend = '0; u_if.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_done", u_if.done, 1'b0);
    chk("rst_quot", u_if.quotient, '0);
    chk("rst_rem",  u_if.remainder, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    wait_idle();

    if (SGN_EN) issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    else        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
    wait_idle();

    issue(32'd5, 32'd0, 1'b0, DIV_ZERO_Q, 32'd5, 1'b1);
    wait_idle();
    issue(32'd5, 32'd0, 1'b1, DIV_ZERO_Q, 32'd5, 1'b1);
    wait_idle();

    if (SGN_EN) issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b1);
    else        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    wait_idle();

    // Requests while busy and during the done cycle must be dropped.
    d0 = n_done;
    issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    u_if.start = 1'b1; u_if.dividend = 32'd9; u_if.divisor = 32'd3;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (u_if.done) break;
      @(posedge clk);
      #1;
    end
    chk("fin_reached", u_if.done, 1'b1);
    u_if.start = 1'b1; u_if.dividend = 32'd9; u_if.divisor = 32'd3;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fin_start_ignored", u_if.busy, 1'b0);
    chk("single_done", n_done - d0, 1);
    wait_idle();

    // Asynchronous reset mid-operation.
    d0 = n_done;
    issue(32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", u_if.busy, 1'b0);
    chk("abort_done", u_if.done, 1'b0);
    chk("abort_quot", u_if.quotient, '0);
    chk("abort_rem",  u_if.remainder, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_idle", u_if.busy, 1'b0);
    issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = $urandom_range(15, 1);
      if (i == 5) b = '0;
      model(a, b, i[0], eq, er, sp);
      issue(a, b, i[0], eq, er, sp);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
